// File: rtl/tmds_decoder.sv
// TMDS character decoder for one HDMI/DVI receive channel: recovers pixel bytes or
// control codes and drives word alignment through bitslip requests to the deserializer.
module tmds_decoder #(
  parameter int SEARCH_LEN  = 1024,
  parameter int LOCK_TOKENS = 8,
  parameter int SLIP_WAIT   = 16
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       locked,
  output logic       bitslip,
  output logic [1:0] fsm_state
);

  localparam int SW = (SEARCH_LEN  > 1) ? $clog2(SEARCH_LEN)  : 1;
  localparam int TW = (LOCK_TOKENS > 1) ? $clog2(LOCK_TOKENS) : 1;
  localparam int WW = (SLIP_WAIT   > 1) ? $clog2(SLIP_WAIT)   : 1;

  localparam logic [SW-1:0] SRCH_LAST = SW'(SEARCH_LEN - 1);
  localparam logic [TW-1:0] TOK_LAST  = TW'(LOCK_TOKENS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] srch_cnt_q, srch_cnt_d;
  logic [TW-1:0] tok_cnt_q, tok_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;

  logic       is_token;
  logic [1:0] tok_code;
  logic [7:0] q;
  logic [7:0] dec;

  // Control token recognition; tok_code is {c1,c0}.
  always_comb begin
    is_token = 1'b1;
    tok_code = 2'b00;
    case (tmds_in)
      10'b1101010100: tok_code = 2'b00;
      10'b0010101011: tok_code = 2'b01;
      10'b0101010100: tok_code = 2'b10;
      10'b1010101011: tok_code = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 set = XOR).
  always_comb begin
    q      = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
    dec    = 8'h00;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = tmds_in[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_SEARCH;
      srch_cnt_q <= '0;
      tok_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      srch_cnt_q <= srch_cnt_d;
      tok_cnt_q  <= tok_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Each counter is cleared by the transition that consumes its terminal value.
  always_comb begin
    state_d    = state_q;
    srch_cnt_d = srch_cnt_q;
    tok_cnt_d  = tok_cnt_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (is_token && (tok_cnt_q == TOK_LAST)) begin
          // A completed token run beats an expiring search window.
          state_d    = ST_LOCKED;
          srch_cnt_d = '0;
          tok_cnt_d  = '0;
        end else begin
          tok_cnt_d = is_token ? (tok_cnt_q + 1'b1) : '0;
          if (srch_cnt_q == SRCH_LAST) begin
            state_d    = ST_SLIP;
            srch_cnt_d = '0;
            tok_cnt_d  = '0;
          end else begin
            srch_cnt_d = srch_cnt_q + 1'b1;
          end
        end
      end
      ST_SLIP: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_SEARCH;
          wait_cnt_d = '0;
          srch_cnt_d = '0;
          tok_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        // srch_cnt measures the run of data characters since the last token.
        if (is_token) begin
          srch_cnt_d = '0;
        end else if (srch_cnt_q == SRCH_LAST) begin
          state_d    = ST_SEARCH;
          srch_cnt_d = '0;
          tok_cnt_d  = '0;
          wait_cnt_d = '0;
        end else begin
          srch_cnt_d = srch_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_SEARCH;
        srch_cnt_d = '0;
        tok_cnt_d  = '0;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign locked    = (state_q == ST_LOCKED);
  assign bitslip   = (state_q == ST_SLIP);
  assign fsm_state = state_q;

  // de qualifies data_out each cycle; there is no backpressure. The pre-update
  // locked value gates decoding, so the lock-acquiring token is not decoded.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_out <= 8'h00;
      de       <= 1'b0;
      c0       <= 1'b0;
      c1       <= 1'b0;
    end else if (state_q == ST_LOCKED) begin
      if (is_token) begin
        data_out <= 8'h00;
        de       <= 1'b0;
        c0       <= tok_code[0];
        c1       <= tok_code[1];
      end else begin
        data_out <= dec;
        de       <= 1'b1;
      end
    end else begin
      data_out <= 8'h00;
      de       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: stimulus pushes expected outputs into exp_q from a
// behavioural model; a monitor pops and compares one entry per clock.
module tb_tmds_decoder;

  localparam int SEARCH_LEN  = 1024;
  localparam int LOCK_TOKENS = 8;
  localparam int SLIP_WAIT   = 16;
  localparam int W           = 13;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds_in = 10'h000;
  logic [7:0] data_out;
  logic       c0, c1, de, locked, bitslip;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e, mon_g;
  int           pulse_cyc[$];

  // Reference model state
  bit         m_locked;
  int         m_run, m_age, m_gap, m_hold;
  logic [1:0] m_c;
  int         enc_cnt;

  logic [9:0] toks[4];

  tmds_decoder #(
    .SEARCH_LEN (SEARCH_LEN),
    .LOCK_TOKENS(LOCK_TOKENS),
    .SLIP_WAIT  (SLIP_WAIT)
  ) dut (
    .vga_clk  (clk),
    .sys_rst  (rst),
    .tmds_in  (tmds_in),
    .data_out (data_out),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
    .locked   (locked),
    .bitslip  (bitslip),
    .fsm_state(fsm_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_g = {data_out, c1, c0, de, locked, bitslip};
      n_checks++;
      if (mon_g === mon_e) n_pass++;
      else $display("FAIL out@cyc%0d: got data=%h c=%b de=%b lk=%b bs=%b, want data=%h c=%b de=%b lk=%b bs=%b",
                    cyc, mon_g[12:5], mon_g[4:3], mon_g[2], mon_g[1], mon_g[0],
                    mon_e[12:5], mon_e[4:3], mon_e[2], mon_e[1], mon_e[0]);
    end
  end

  always @(posedge clk) begin
    #1;
    if (bitslip === 1'b1) pulse_cyc.push_back(cyc);
  end

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  function automatic bit tok_code(input logic [9:0] w, output logic [1:0] c);
    c = 2'b00;
    if (w == TOK0) begin c = 2'b00; return 1'b1; end
    if (w == TOK1) begin c = 2'b01; return 1'b1; end
    if (w == TOK2) begin c = 2'b10; return 1'b1; end
    if (w == TOK3) begin c = 2'b11; return 1'b1; end
    return 1'b0;
  endfunction

  // Decode by inverting the transmitter: find the byte whose XOR/XNOR chain,
  // in the mode named by bit 8 and inverted per bit 9, reproduces the word.
  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] vb, qm, enc;
    for (int v = 0; v < 256; v++) begin
      vb    = 8'(v);
      qm[0] = vb[0];
      for (int i = 1; i < 8; i++) qm[i] = w[8] ? (qm[i-1] ^ vb[i]) : ~(qm[i-1] ^ vb[i]);
      enc = w[9] ? ~qm : qm;
      if (enc == w[7:0]) return vb;
    end
    return 8'h00;
  endfunction

  // Full DC-balanced DVI data encoder.
  task automatic encode(input logic [7:0] dv, output logic [9:0] w);
    logic [8:0] qm;
    bit         use_xnor;
    int         n1, n1q, n0q;
    n1       = $countones(dv);
    use_xnor = (n1 > 4) || (n1 == 4 && dv[0] == 1'b0);
    qm[0]    = dv[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ dv[i]) : (qm[i-1] ^ dv[i]);
    qm[8] = ~use_xnor;
    n1q   = $countones(qm[7:0]);
    n0q   = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      w = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8] == 1'b0) enc_cnt += n0q - n1q;
      else               enc_cnt += n1q - n0q;
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -(qm[8] ? 0 : 2) + n1q - n0q;
    end
  endtask

  function automatic logic [9:0] rot(input logic [9:0] t, input int k);
    logic [9:0] r;
    r = t;
    for (int i = 0; i < k; i++) r = {r[0], r[9:1]};
    return r;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    logic [1:0] c;
    w = 10'($urandom_range(0, 1023));
    if (tok_code(w, c)) w = 10'h100;
    return w;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_run = 0; m_age = 0; m_gap = 0; m_hold = 0;
    m_c = 2'b00;
  endtask

  // One character of behaviour: outputs use the lock status held before the edge.
  // m_hold counts the slip cycle plus the settle cycles.
  task automatic model_step(input logic [9:0] x, input int want, output logic [W-1:0] e);
    logic [1:0] code;
    logic [7:0] d;
    bit         tok, de_x;
    tok  = tok_code(x, code);
    d    = 8'h00;
    de_x = 1'b0;
    if (m_locked) begin
      if (tok) m_c = code;
      else begin
        de_x = 1'b1;
        d    = (want >= 0) ? 8'(want) : ref_decode(x);
      end
    end
    if (m_locked) begin
      m_gap = tok ? 0 : m_gap + 1;
      if (m_gap == SEARCH_LEN) begin
        m_locked = 1'b0; m_gap = 0; m_age = 0; m_run = 0;
      end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin m_age = 0; m_run = 0; end
    end else begin
      m_age++;
      m_run = tok ? m_run + 1 : 0;
      if (m_run == LOCK_TOKENS) begin
        m_locked = 1'b1; m_gap = 0; m_run = 0; m_age = 0;
      end else if (m_age == SEARCH_LEN) begin
        m_hold = SLIP_WAIT + 1; m_age = 0; m_run = 0;
      end
    end
    e = {d, m_c, de_x, m_locked, (m_hold == SLIP_WAIT + 1)};
  endtask

  // Driver tasks: entered and left at a falling edge.
  task automatic send_w(input logic [9:0] x, input int want);
    logic [W-1:0] e;
    tmds_in = x;
    model_step(x, want, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic send(input logic [9:0] x);
    send_w(x, -1);
  endtask

  task automatic do_reset(input int n);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", int'({data_out, c1, c0, de, locked, bitslip}), 0);
    model_reset();
    for (int i = 0; i < n; i++) begin
      tmds_in = 10'($urandom_range(0, 1023));
      exp_q.push_back('0);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] w;
    int         off, after_lock;
    bit         done;

    toks = '{TOK0, TOK1, TOK2, TOK3};
    model_reset();
    enc_cnt = 0;
    @(negedge clk);

    // Reset and first lock
    do_reset(5);
    for (int i = 0; i < LOCK_TOKENS; i++) send(TOK0);
    check("lock_after_8", int'(locked), 1);
    check("c_after_lock", int'({c1, c0}), 0);
    send(TOK3);
    check("c_after_tok3", int'({c1, c0}), 3);

    // Data decode
    send(10'b0100000000);
    send(10'b1111111111);
    check("dec_3ff", int'(data_out), 0);
    enc_cnt = 0;
    for (int v = 0; v < 256; v++) begin
      encode(8'(v), w);
      send_w(w, v);
    end
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 2) send(toks[$urandom_range(0, 3)]);
      else                          send(rand_data());
    end

    // Lock loss boundary
    send(TOK1);
    for (int i = 0; i < SEARCH_LEN - 1; i++) send(rand_data());
    send(TOK2);
    check("gap_tok_keeps_lock", int'(locked), 1);
    for (int i = 0; i < SEARCH_LEN - 1; i++) send(rand_data());
    check("gap_1023", int'(locked), 1);
    send(rand_data());
    check("gap_1024", int'(locked), 0);

    // Near-lock interruption
    do_reset(3);
    for (int i = 0; i < LOCK_TOKENS - 1; i++) send(TOK0);
    send(rand_data());
    for (int i = 0; i < LOCK_TOKENS - 1; i++) send(TOK0);
    check("near_lock_7", int'(locked), 0);
    send(TOK0);
    check("near_lock_8", int'(locked), 1);
    for (int i = 0; i < 3; i++) send(rand_data());

    // Asynchronous reset while locked and outputting data
    do_reset(4);

    // Lock landing on the last search slot
    pulse_cyc.delete();
    for (int i = 0; i < SEARCH_LEN - LOCK_TOKENS; i++) send(rand_data());
    for (int i = 0; i < LOCK_TOKENS; i++) send(TOK0);
    check("simul_locked", int'(locked), 1);
    send(TOK0);
    check("simul_no_slip", pulse_cyc.size(), 0);

    // Alignment search through a misaligned deserializer
    do_reset(3);
    pulse_cyc.delete();
    off        = 7;
    after_lock = 0;
    done       = 1'b0;
    for (int k = 0; k < 5000 && !done; k++) begin
      send(rot(TOK0, off));
      if (bitslip === 1'b1) off = (off + 1) % 10;
      if (m_locked) after_lock++;
      if (after_lock > 20) done = 1'b1;
    end
    check("align_locked", int'(locked), 1);
    check("align_pulses", pulse_cyc.size(), 3);
    if (pulse_cyc.size() >= 3) begin
      check("align_gap1", pulse_cyc[1] - pulse_cyc[0], SEARCH_LEN + SLIP_WAIT + 1);
      check("align_gap2", pulse_cyc[2] - pulse_cyc[1], SEARCH_LEN + SLIP_WAIT + 1);
    end

    // Random locked traffic
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) send(toks[$urandom_range(0, 3)]);
      else                           send(rand_data());
    end

    repeat (3) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
